// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
// The master side is the fetch stage + decode stage driver; the slave side is the buffer.
interface if_id_buffer_if;
  logic [31:0] instruction_in;
  logic [63:0] PC_in;
  logic [63:0] PC_branch_link_in;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        IFIDWrite;
  logic        flush;
  logic [31:0] instruction_out;
  logic [63:0] PC_out;
  logic [63:0] PC_branch_link_out;
  logic        valid_out;
  logic [1:0]  count;

  modport master (
    output instruction_in, PC_in, PC_branch_link_in, fetch_valid, IFIDWrite, flush,
    input  fetch_ready, instruction_out, PC_out, PC_branch_link_out, valid_out, count
  );

  modport slave (
    input  instruction_in, PC_in, PC_branch_link_in, fetch_valid, IFIDWrite, flush,
    output fetch_ready, instruction_out, PC_out, PC_branch_link_out, valid_out, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// 2-entry circular IF/ID FIFO between fetch and decode; IFID_BRANCH_LINK_EN stores the link value per entry.
// Latency: one cycle from push to head, no bypass; empty head reads as NOP with zero PCs.
// Backpressure: fetch_ready = not full, from registered count only; flush beats push and pop.
module if_id_buffer (
  input  logic          clock,
  input  logic          reset,
  if_id_buffer_if.slave bus
);

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_instr [2];
  logic [63:0] r_pc    [2];
`ifdef IFID_BRANCH_LINK_EN
  logic [63:0] r_link  [2];
`else
  logic [63:0] w_unused_link;
`endif

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);
  // A pop in the same cycle never frees a slot for a push when full.
  assign w_push  = bus.fetch_valid && !w_full && !bus.flush;
  assign w_pop   = bus.IFIDWrite && !w_empty && !bus.flush;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= bus.instruction_in;
      r_pc[r_wr_ptr]    <= bus.PC_in;
`ifdef IFID_BRANCH_LINK_EN
      r_link[r_wr_ptr]  <= bus.PC_branch_link_in;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (bus.flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset, so the head is masked whenever the buffer is empty.
  assign bus.fetch_ready     = !w_full;
  assign bus.valid_out       = !w_empty;
  assign bus.count           = r_count;
  assign bus.instruction_out = w_empty ? NOP_INSTR : r_instr[r_rd_ptr];
  assign bus.PC_out          = w_empty ? 64'd0 : r_pc[r_rd_ptr];
`ifdef IFID_BRANCH_LINK_EN
  assign bus.PC_branch_link_out = w_empty ? 64'd0 : r_link[r_rd_ptr];
`else
  assign w_unused_link          = bus.PC_branch_link_in;
  assign bus.PC_branch_link_out = w_empty ? 64'd0 : r_pc[r_rd_ptr] + 64'd4;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios plus random traffic against a queue model.
module tb_if_id_buffer;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] lk;
  } ent_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  ent_t q[$];

  if_id_buffer_if bus ();

  if_id_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] ins, input logic [63:0] pc,
                       input logic [63:0] lk, input logic ifw, input logic fl);
    bus.fetch_valid       = fv;
    bus.instruction_in    = ins;
    bus.PC_in             = pc;
    bus.PC_branch_link_in = lk;
    bus.IFIDWrite         = ifw;
    bus.flush             = fl;
  endtask

  // Model: the buffer is just a bounded queue of at most two entries.
  task automatic model_step();
    ent_t e;
    bit   push;
    bit   pop;
    push = bus.fetch_valid && (q.size() < 2) && !bus.flush;
    pop  = bus.IFIDWrite && (q.size() > 0) && !bus.flush;
    e.ins = bus.instruction_in;
    e.pc  = bus.PC_in;
`ifdef IFID_BRANCH_LINK_EN
    e.lk  = bus.PC_branch_link_in;
`else
    e.lk  = bus.PC_in + 64'd4;
`endif
    if (bus.flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] e_ins;
    logic [63:0] e_pc;
    logic [63:0] e_lk;
    e_ins = 32'hD503201F;
    e_pc  = 64'd0;
    e_lk  = 64'd0;
    if (q.size() > 0) begin
      e_ins = q[0].ins;
      e_pc  = q[0].pc;
      e_lk  = q[0].lk;
    end
    check_eq({tag, "_count"}, 64'(bus.count), 64'(q.size()));
    check_eq({tag, "_valid"}, 64'(bus.valid_out), 64'(q.size() != 0));
    check_eq({tag, "_ready"}, 64'(bus.fetch_ready), 64'(q.size() != 2));
    check_eq({tag, "_ins"}, 64'(bus.instruction_out), 64'(e_ins));
    check_eq({tag, "_pc"}, bus.PC_out, e_pc);
    check_eq({tag, "_lk"}, bus.PC_branch_link_out, e_lk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    #12;
    check_outputs("reset");
    reset = 1'b1;
    tick();
    check_outputs("idle");
    check_eq("idle_ins_nop", 64'(bus.instruction_out), 64'hD503201F);

    // Single push, decode stalled.
    drive(1'b1, 32'h8B020020, 64'h40, 64'h44, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_outputs("push1");
    check_eq("push1_pc", bus.PC_out, 64'h40);
    check_eq("push1_lk", bus.PC_branch_link_out, 64'h44);
    drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    tick();
    check_outputs("drain1");

    // Fill to full; third push must be refused.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 64'(4 * i), 64'(4 * i + 4), 1'b0, 1'b0);
      tick();
      check_outputs("fill");
    end
    check_eq("fill_count", 64'(bus.count), 64'd2);
    check_eq("fill_ready", 64'(bus.fetch_ready), 64'd0);
    drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_eq("fill_head", bus.PC_out, 64'h0);

    // Full with push and pop together: only the pop happens.
    drive(1'b1, 32'hAAAA, 64'h8, 64'hC, 1'b1, 1'b0);
    tick();
    check_outputs("fullpp");
    check_eq("fullpp_count", 64'(bus.count), 64'd1);
    check_eq("fullpp_pc", bus.PC_out, 64'h4);

    // Flush with a concurrent push discards both.
    drive(1'b1, 32'hBBBB, 64'h100, 64'h104, 1'b0, 1'b1);
    tick();
    check_outputs("flush");
    check_eq("flush_valid", 64'(bus.valid_out), 64'd0);
    drive(1'b1, 32'hCCCC, 64'h200, 64'h204, 1'b0, 1'b0);
    tick();
    check_outputs("postflush");
    check_eq("postflush_pc", bus.PC_out, 64'h200);

    // Pop on empty does nothing.
    drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    tick();
    tick();
    check_outputs("emptypop");

    // Asynchronous reset while full.
    drive(1'b1, 32'h11, 64'h10, 64'h14, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 64'h20, 64'h24, 1'b0, 1'b0);
    tick();
    check_eq("pre_arst_count", 64'(bus.count), 64'd2);
    drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 64'(bus.valid_out), 64'd0);
    check_eq("arst_count", 64'(bus.count), 64'd0);
    q.delete();
    check_outputs("arst");
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 32'h33, 64'h300, 64'h304, 1'b0, 1'b0);
    tick();
    check_outputs("after_arst");
    check_eq("after_arst_pc", bus.PC_out, 64'h300);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom % 2) == 0, ($urandom % 16) == 0);
      tick();
      check_outputs("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low. Ports: clock, reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset; 0 clears all state.
REQ-004 instruction_in  input  32  fetched instruction word from the fetch stage.
REQ-005 PC_in  input  64  PC of instruction_in.
REQ-006 PC_branch_link_in  input  64  PC_in+4 from fetch, used as the link value.
REQ-007 fetch_valid  input  1  fetch stage offers an entry this cycle.
REQ-008 fetch_ready  output  1  buffer accepts an entry; fetch uses it as PCWrite.
REQ-009 IFIDWrite  input  1  decode consumes the head entry this cycle; 0 = decode stall.
REQ-010 flush  input  1  discard all buffered entries (taken branch / Branchreg).
REQ-011 instruction_out  output  32  head instruction to decode.
REQ-012 PC_out  output  64  head PC.
REQ-013 PC_branch_link_out  output  64  head link value.
REQ-014 valid_out  output  1  head entry is valid.
REQ-015 count  output  2  number of buffered entries, 0..2.

Function
REQ-016 SHALL be a 2-entry circular FIFO: 1-bit read pointer, 1-bit write pointer, 2-bit count.
REQ-017 fetch_ready SHALL be (count != 2), derived only from registered state, with no combinational path from IFIDWrite.
REQ-018 Push SHALL occur when fetch_valid && fetch_ready && !flush. The entry is written at the write pointer, which then toggles.
REQ-019 Pop SHALL occur when IFIDWrite && valid_out && !flush. The read pointer then toggles.
REQ-020 valid_out SHALL be (count != 0).
REQ-021 Outputs SHALL present the entry at the read pointer directly from storage.
REQ-022 Latency SHALL be one cycle: an entry pushed at edge N appears on the outputs after edge N; there is no same-cycle bypass.
REQ-023 When empty, instruction_out SHALL be 32'hD503201F (NOP), and PC_out and PC_branch_link_out SHALL be 0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged. Both pointers advance.
REQ-025 When full, push SHALL be blocked even if a pop occurs in the same cycle.
REQ-026 When empty, IFIDWrite=1 SHALL have no effect.
REQ-027 flush SHALL have priority over push and pop. At the next edge, count and both pointers are 0, and any same-cycle push is discarded.
REQ-028 Pointer wrap-around SHALL be implicit in the 1-bit toggle. count SHALL never exceed 2 or go below 0.

Reset
REQ-029 reset=0 SHALL asynchronously clear count and both pointers. The resulting outputs are valid_out=0, fetch_ready=1, count=0, and the NOP/zero outputs of REQ-023.
REQ-030 Storage contents SHALL NOT require reset. Outputs SHALL be masked while count=0.
REQ-031 Reset asserted mid-operation SHALL drop all entries. The first push after reset release lands in entry 0.

Configuration
REQ-032 Macro IFID_BRANCH_LINK_EN SHALL control storage of the link value.
- Defined: PC_branch_link_in is stored per entry and output as PC_branch_link_out.
- Undefined: PC_branch_link_in is ignored and not stored. PC_branch_link_out SHALL be PC_out+4 when valid_out=1, else 0.

Verification
REQ-033 Reset release, fetch_valid=0 -> valid_out=0, fetch_ready=1, count=0, instruction_out=32'hD503201F.
REQ-034 Push instruction 32'h8B020020 with PC 0x40, IFIDWrite=0 -> next cycle valid_out=1, PC_out=0x40, PC_branch_link_out=0x44, count=1.
REQ-035 Push PC 0x0, 0x4, 0x8 on consecutive cycles with IFIDWrite=0 -> count=2 and fetch_ready=0 after the second edge. The 0x8 push is not taken. IFIDWrite=1 then yields PC_out 0x0, then 0x4.
REQ-036 Full buffer with push and pop in the same cycle -> one pop only, count=1, PC_out advances to the second entry.
REQ-037 count=1, flush=1 together with a push of PC 0x100 -> next cycle count=0, valid_out=0. The following push of PC 0x200 appears at PC_out.
REQ-038 Assert reset=0 asynchronously mid-clock while count=2 -> valid_out=0 and count=0 immediately, without waiting for a clock edge.
